// File: rtl/frame_buffer_ctrl.sv
// Frame store between a pixel writer and a display reader with a 2-cycle read pipeline.
// Define FRAME_BUFFER_DBUF_EN for double buffering with rd_vsync-timed bank swaps.
module frame_buffer_ctrl #(
    parameter int DATA_W  = 16,
    parameter int H_RES   = 320,
    parameter int V_RES   = 240,
    parameter int COUNT_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [COUNT_W-1:0] wr_hcount,
    input  logic [COUNT_W-1:0] wr_vcount,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               wr_frame_end,
    input  logic               rd_en,
    input  logic [COUNT_W-1:0] rd_hcount,
    input  logic [COUNT_W-1:0] rd_vcount,
    input  logic               rd_vsync,
    output logic [DATA_W-1:0]  rd_data,
    output logic               rd_valid,
    output logic               front_bank,
    output logic [7:0]         frame_count,
    output logic               dbg_wr_state
);

    localparam int DEPTH = H_RES * V_RES;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LIN_W = 2 * COUNT_W + 2;
    localparam logic [COUNT_W:0] H_LIM = (COUNT_W+1)'(H_RES);
    localparam logic [COUNT_W:0] V_LIM = (COUNT_W+1)'(V_RES);

    function automatic logic in_frame(input logic [COUNT_W-1:0] h,
                                      input logic [COUNT_W-1:0] v);
        return ({1'b0, h} < H_LIM) && ({1'b0, v} < V_LIM);
    endfunction

    // Full-width product so large coordinates cannot alias before the range check.
    function automatic logic [AW-1:0] lin_addr(input logic [COUNT_W-1:0] h,
                                               input logic [COUNT_W-1:0] v);
        logic [LIN_W-1:0] lin;
        lin = LIN_W'(v) * LIN_W'(H_RES) + LIN_W'(h);
        return AW'(lin);
    endfunction

    logic              wr_fire;
    logic              wr_in_frame;
    logic              rd_in_frame;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_raw_q;

    always_comb begin
        wr_in_frame = in_frame(wr_hcount, wr_vcount);
        rd_in_frame = in_frame(rd_hcount, rd_vcount);
        wr_addr     = wr_in_frame ? lin_addr(wr_hcount, wr_vcount) : '0;
        rd_addr     = rd_in_frame ? lin_addr(rd_hcount, rd_vcount) : '0;
    end

    assign wr_fire = wr_valid && wr_ready;

`ifdef FRAME_BUFFER_DBUF_EN
    typedef enum logic {
        ST_FILL      = 1'b0,
        ST_WAIT_SWAP = 1'b1
    } wr_state_e;

    wr_state_e  state_q, state_d;
    logic       front_bank_q, front_bank_d;
    logic [7:0] frame_count_q, frame_count_d;
    logic       wr_ready_c;
    logic       back_bank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_FILL;
            front_bank_q  <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            front_bank_q  <= front_bank_d;
            frame_count_q <= frame_count_d;
        end
    end

    // A vsync seen while still filling is ignored; the swap waits for the next one.
    always_comb begin
        state_d       = state_q;
        front_bank_d  = front_bank_q;
        frame_count_d = frame_count_q;
        wr_ready_c    = 1'b0;
        case (state_q)
            ST_FILL: begin
                wr_ready_c = 1'b1;
                if (wr_valid && wr_frame_end) begin
                    state_d = ST_WAIT_SWAP;
                end
            end
            ST_WAIT_SWAP: begin
                if (rd_vsync) begin
                    state_d       = ST_FILL;
                    front_bank_d  = ~front_bank_q;
                    frame_count_d = frame_count_q + 8'd1;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    assign back_bank    = ~front_bank_q;
    assign wr_ready     = wr_ready_c;
    assign front_bank   = front_bank_q;
    assign frame_count  = frame_count_q;
    assign dbg_wr_state = (state_q == ST_WAIT_SWAP);

    logic [DATA_W-1:0] mem [2][DEPTH];

    // Bank index is the MSB of the storage address; writer and reader never share a bank.
    always_ff @(posedge clk) begin
        if (wr_fire && wr_in_frame) begin
            mem[back_bank][wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_raw_q <= mem[front_bank_q][rd_addr];
        end
    end
`else
    logic [7:0] frame_count_q, frame_count_d;
    logic       unused_vsync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count_q <= 8'd0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    always_comb begin
        frame_count_d = frame_count_q;
        if (wr_fire && wr_frame_end) begin
            frame_count_d = frame_count_q + 8'd1;
        end
    end

    assign unused_vsync = rd_vsync;
    assign wr_ready     = 1'b1;
    assign front_bank   = 1'b0;
    assign frame_count  = frame_count_q;
    assign dbg_wr_state = 1'b0;

    logic [DATA_W-1:0] mem [DEPTH];

    // Read-first: a same-cycle write to the read address is seen by later reads only.
    always_ff @(posedge clk) begin
        if (wr_fire && wr_in_frame) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_raw_q <= mem[rd_addr];
        end
    end
`endif

    logic              rd_s1_valid_q, rd_s1_valid_d;
    logic              rd_s1_in_frame_q, rd_s1_in_frame_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_s1_valid_q    <= 1'b0;
            rd_s1_in_frame_q <= 1'b0;
            rd_valid_q       <= 1'b0;
            rd_data_q        <= '0;
        end else begin
            rd_s1_valid_q    <= rd_s1_valid_d;
            rd_s1_in_frame_q <= rd_s1_in_frame_d;
            rd_valid_q       <= rd_valid_d;
            rd_data_q        <= rd_data_d;
        end
    end

    // Out-of-frame reads still produce a beat, carrying zero instead of RAM contents.
    always_comb begin
        rd_s1_valid_d    = rd_en;
        rd_s1_in_frame_d = rd_en && rd_in_frame;
        rd_valid_d       = rd_s1_valid_q;
        rd_data_d        = rd_data_q;
        if (rd_s1_valid_q) begin
            rd_data_d = rd_s1_in_frame_q ? rd_raw_q : '0;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule
